// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame engine.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_frame_bit_sampler.sv
// Per-bit edge counter and 3-sample majority voter centred on the bit middle.
module rx_bit_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic               enable,
  input  logic [PRESC_W-1:0] prescale,
  output logic               sampled_bit,
  output logic               bit_done
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last;
  logic [1:0]         ones;
  logic [1:0]         ones_next;

  assign half      = prescale >> 1;
  assign last      = prescale - ONE;
  assign ones_next = ones + {1'b0, RX_IN};
  assign bit_done  = enable && (edge_cnt == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt    <= '0;
      ones        <= '0;
      sampled_bit <= 1'b0;
    end else if (!enable) begin
      edge_cnt <= '0;
      ones     <= '0;
    end else begin
      edge_cnt <= (edge_cnt == last) ? '0 : edge_cnt + ONE;
      if (edge_cnt == half - ONE) begin
        ones <= {1'b0, RX_IN};
      end else if (edge_cnt == half) begin
        ones <= ones_next;
      end else if (edge_cnt == half + ONE) begin
        // two or more ones out of three samples
        sampled_bit <= ones_next[1];
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start detect, LSB-first deserialise, parity and stop check.
// state  | meaning
// IDLE   | line idle, settings tracked, waiting for RX_IN low
// START  | validating start bit (majority 1 = glitch, back to IDLE)
// DATA   | shifting in DATA_W data bits
// PARITY | checking the parity bit
// STOP   | checking the stop bit and issuing the result pulse
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_typ,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err
);

  rx_state_t          state, next_state;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q, par_typ_q;
  logic [DATA_W-1:0]  shift_q, shift_d, pdata_d;
  logic [3:0]         bit_cnt, bit_cnt_d;
  logic               perr, perr_d;
  logic               dv_d, pe_d, se_d;
  logic               sampled_bit, bit_done;
  logic               presc_ok, exp_par;

  rx_bit_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .enable     (state != IDLE),
    .prescale   (presc_q),
    .sampled_bit(sampled_bit),
    .bit_done   (bit_done)
  );

  // Illegal ratios never leave IDLE, so a bad prescale cannot wedge the FSM.
  assign presc_ok = (prescale == PRESC_W'(PRESC_8))  ||
                    (prescale == PRESC_W'(PRESC_16)) ||
                    (prescale == PRESC_W'(PRESC_32));
  assign exp_par  = (par_typ_q == PAR_EVEN) ? ^shift_q : ~^shift_q;

  always_comb begin
    next_state = state;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt;
    perr_d     = perr;
    pdata_d    = P_DATA;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN && presc_ok) begin
          next_state = START;
          bit_cnt_d  = '0;
          perr_d     = 1'b0;
        end
      end
      START: begin
        if (bit_done) next_state = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {sampled_bit, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_W - 1)) next_state = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) begin
          if (sampled_bit != exp_par) perr_d = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          next_state = IDLE;
          if (!sampled_bit) begin
            se_d = 1'b1;
          end else if (perr) begin
            pe_d = 1'b1;
          end else begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      perr       <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else begin
      state      <= next_state;
      shift_q    <= shift_d;
      bit_cnt    <= bit_cnt_d;
      perr       <= perr_d;
      P_DATA     <= pdata_d;
      data_valid <= dv_d;
      par_err    <= pe_d;
      stp_err    <= se_d;
      if (state == IDLE) begin
        presc_q   <= prescale;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench: per-cycle compare against a timestamp-based line model plus directed frame checks.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid, par_err, stp_err;

  uart_rx_frame #(.DATA_W(8), .PRESC_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .prescale  (prescale),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line model: a frame detected at edge t0 has bit b sampled at edges
  // t0+b*P+P/2 .. +2 and its decision lands on edge t0+(b+1)*P.
  bit         m_busy = 1'b0;
  int         m_t0, m_p, m_n, m_k, m_b, m_c;
  bit         m_par, m_odd, m_pexp;
  int         m_ones[11];
  bit         m_bit[11];
  logic [7:0] m_d;
  logic [7:0] exp_pdata = 8'h00;
  bit         exp_dv = 1'b0, exp_pe = 1'b0, exp_se = 1'b0;

  always @(posedge clk) begin
    cyc++;
    exp_dv = 1'b0;
    exp_pe = 1'b0;
    exp_se = 1'b0;
    if (rst) begin
      m_busy    = 1'b0;
      exp_pdata = 8'h00;
    end else if (!m_busy) begin
      if (RX_IN == 1'b0) begin
        m_busy = 1'b1;
        m_t0   = cyc;
        m_p    = int'(prescale);
        m_n    = par_en ? 11 : 10;
        m_par  = par_en;
        m_odd  = par_typ;
        foreach (m_ones[i]) m_ones[i] = 0;
      end
    end else begin
      m_k = cyc - m_t0;
      m_b = (m_k - 1) / m_p;
      m_c = (m_k - 1) % m_p;
      if (m_c >= m_p / 2 - 1 && m_c <= m_p / 2 + 1 && RX_IN) m_ones[m_b]++;
      if (m_c == m_p - 1) begin
        m_bit[m_b] = (m_ones[m_b] >= 2);
        if (m_b == 0 && m_bit[0]) begin
          m_busy = 1'b0;
        end else if (m_b == m_n - 1) begin
          m_busy = 1'b0;
          for (int i = 0; i < 8; i++) m_d[i] = m_bit[i + 1];
          m_pexp = m_odd ? ~^m_d : ^m_d;
          if (!m_bit[m_b]) exp_se = 1'b1;
          else if (m_par && (m_bit[9] != m_pexp)) exp_pe = 1'b1;
          else begin
            exp_dv    = 1'b1;
            exp_pdata = m_d;
          end
        end
      end
    end
  end

  int n_dv = 0, n_pe = 0, n_se = 0;
  int dv_cyc = 0, dv_cyc_prev = 0, pe_cyc = 0, se_cyc = 0;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("data_valid", data_valid, exp_dv);
      chk("par_err", par_err, exp_pe);
      chk("stp_err", stp_err, exp_se);
      chk("P_DATA", P_DATA, exp_pdata);
      if (data_valid === 1'b1) begin
        n_dv++;
        dv_cyc_prev = dv_cyc;
        dv_cyc = cyc;
      end
      if (par_err === 1'b1) begin
        n_pe++;
        pe_cyc = cyc;
      end
      if (stp_err === 1'b1) begin
        n_se++;
        se_cyc = cyc;
      end
    end
  end

  always @(posedge clk) begin
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
      $fatal(1, "watchdog");
    end
  end

  int t_start;

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a negedge; glitch inverts the line for one cycle,
  // abort pulses rst at that cycle and returns the line to idle.
  task automatic send_frame(input logic [7:0] data, input int p, input bit pen, input bit ptyp,
                            input bit bad_par, input bit stop_val, input int glitch,
                            input int abort, input bit scramble);
    logic [10:0] bits;
    int nb;
    bits     = '1;
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (pen) begin
      bits[9]  = (ptyp ? ~^data : ^data) ^ bad_par;
      bits[10] = stop_val;
      nb = 11;
    end else begin
      bits[9] = stop_val;
      nb = 10;
    end
    t_start = cyc + 1;
    for (int i = 0; i < nb * p; i++) begin
      if (i == abort) begin
        rst   = 1'b1;
        RX_IN = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      RX_IN = bits[i / p] ^ (i == glitch);
      if (scramble && i == p) begin
        prescale = 6'(8 << $urandom_range(0, 2));
        par_en   = 1'($urandom_range(0, 1));
        par_typ  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
  endtask

  int d_dv, d_pe, d_se, gap, rp;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_P_DATA", P_DATA, 8'h00);
    chk("reset_data_valid", data_valid, 1'b0);
    chk("reset_par_err", par_err, 1'b0);
    chk("reset_stp_err", stp_err, 1'b0);
    idle(4);

    // even parity 0xA5, P=8
    d_dv = n_dv;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(6);
    chk("a5_count", n_dv - d_dv, 1);
    chk("a5_latency", dv_cyc - t_start, 88);
    chk("a5_data", P_DATA, 8'hA5);

    // odd parity 0x3C with wrong parity bit, P=16
    d_dv = n_dv; d_pe = n_pe;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0);
    idle(6);
    chk("3c_par_count", n_pe - d_pe, 1);
    chk("3c_latency", pe_cyc - t_start, 176);
    chk("3c_no_valid", n_dv - d_dv, 0);
    chk("3c_data_kept", P_DATA, 8'hA5);

    // stop bit low, P=8 no parity
    d_dv = n_dv; d_pe = n_pe; d_se = n_se;
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
    idle(6);
    chk("ff_stp_count", n_se - d_se, 1);
    chk("ff_latency", se_cyc - t_start, 80);
    chk("ff_no_other", (n_dv - d_dv) + (n_pe - d_pe), 0);

    // start glitch at P=32, then a good frame
    prescale = 6'd32; par_en = 1'b0;
    d_dv = n_dv; d_pe = n_pe; d_se = n_se;
    RX_IN = 1'b0;
    repeat (10) @(negedge clk);
    idle(40);
    chk("glitch_no_pulse", (n_dv - d_dv) + (n_pe - d_pe) + (n_se - d_se), 0);
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(6);
    chk("81_count", n_dv - d_dv, 1);
    chk("81_data", P_DATA, 8'h81);

    // one-cycle line inversion at mid-sample of data bit 3
    d_dv = n_dv;
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4 * 8 + 4 + 1, -1, 1'b0);
    idle(6);
    chk("00_count", n_dv - d_dv, 1);
    chk("00_data", P_DATA, 8'h00);

    // back-to-back frames; the receiver re-arms one cycle after stop
    d_dv = n_dv;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(6);
    chk("b2b_count", n_dv - d_dv, 2);
    chk("b2b_data", P_DATA, 8'h34);
    gap = dv_cyc - dv_cyc_prev;
    checks++;
    if (gap < 80 || gap > 81) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles between pulses, expected 80..81", gap);
    end

    // reset during data bit 4, then a clean frame
    d_dv = n_dv; d_pe = n_pe; d_se = n_se;
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5 * 8 + 2, 1'b0);
    chk("rst_P_DATA", P_DATA, 8'h00);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_par_err", par_err, 1'b0);
    chk("rst_stp_err", stp_err, 1'b0);
    idle(20);
    chk("rst_no_pulse", (n_dv - d_dv) + (n_pe - d_pe) + (n_se - d_se), 0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
    idle(6);
    chk("55_count", n_dv - d_dv, 1);
    chk("55_data", P_DATA, 8'h55);

    // randomized frames; settings scrambled mid-frame must not matter
    for (int f = 0; f < 40; f++) begin
      rp = 8 << $urandom_range(0, 2);
      send_frame(8'($urandom_range(0, 255)), rp, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(rp, 9 * rp - 1)) : -1,
                 -1, 1'b1);
      idle($urandom_range(0, 4));
    end
    idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
